// File: rtl/dma_pkg.sv
// Shared types and helpers for the DMA request arbiter.
package dma_pkg;

    localparam int unsigned N_CH_DEFAULT = 2;
    localparam int unsigned MAX_CH       = 8;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        OWN,
        RELEASE
    } arb_state_t;

    function automatic logic [MAX_CH-1:0] onehot_of(input logic [2:0] idx);
        logic [MAX_CH-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/dma_req_arbiter_if.sv
// Peripheral request / CPU hold handshake / DMA core grant bundle.
interface dma_req_arbiter_if
    import dma_pkg::*;
#(
    parameter int unsigned N_CH = N_CH_DEFAULT
);
    logic [N_CH-1:0] dreq;
    logic            hack;
    logic            eop;
    logic            hrq;
    logic            dma_ctrl;
    logic [N_CH-1:0] ch_req;
    logic [N_CH-1:0] dack;
    logic            busy;
    logic            timeout_err;

    // master: the arbiter; slave: peripherals, CPU and DMA core around it
    modport master (
        input  dreq, hack, eop,
        output hrq, dma_ctrl, ch_req, dack, busy, timeout_err
    );

    modport slave (
        output dreq, hack, eop,
        input  hrq, dma_ctrl, ch_req, dack, busy, timeout_err
    );

endinterface

// File: rtl/rr_priority_picker.sv
// Combinational rotating-priority picker: first set request at or after ptr, wrapping.
module rr_priority_picker
    import dma_pkg::*;
#(
    parameter  int unsigned N_CH = N_CH_DEFAULT,
    localparam int unsigned PW   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic [N_CH-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic            valid,
    output logic [PW-1:0]   idx
);

    logic [N_CH-1:0] rot;
    int              pos;

    always_comb begin
        rot   = N_CH'({req, req} >> ptr);
        valid = |req;
        idx   = '0;
        pos   = 0;
        // Walk downwards so the lowest rotated position is the one left in idx.
        for (int i = int'(N_CH) - 1; i >= 0; i--) begin
            if (rot[i]) begin
                pos = int'(ptr) + i;
                if (pos >= int'(N_CH)) pos = pos - int'(N_CH);
                idx = PW'(pos);
            end
        end
    end

endmodule

// File: rtl/dma_req_arbiter.sv
// DMA front-end: picks a channel round-robin, runs hrq/hack with the CPU, grants the core.
module dma_req_arbiter
    import dma_pkg::*;
#(
    parameter int unsigned N_CH         = N_CH_DEFAULT,
    parameter int unsigned HACK_TIMEOUT = 16
) (
    input logic              clk,
    input logic              rst_n,
    dma_req_arbiter_if.master bus
);

    localparam int unsigned PW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned CW = $clog2(HACK_TIMEOUT + 1);

    arb_state_t      state_q, state_d;
    logic [PW-1:0]   win_q, win_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            eop_q;
    logic            hrq_q, hrq_d;
    logic            dma_q, dma_d;
    logic [N_CH-1:0] ch_req_q, ch_req_d;
    logic [N_CH-1:0] dack_q, dack_d;
    logic            busy_q, busy_d;
    logic            terr_q, terr_d;

    logic            pick_valid;
    logic [PW-1:0]   pick_idx;
    logic [PW-1:0]   ptr_next;

    rr_priority_picker #(
        .N_CH (N_CH)
    ) u_picker (
        .req   (bus.dreq),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Served (or abandoned) channel drops to lowest priority.
    assign ptr_next = (win_q == PW'(N_CH - 1)) ? '0 : win_q + PW'(1);

    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        ptr_d    = ptr_q;
        cnt_d    = '0;
        hrq_d    = hrq_q;
        dma_d    = dma_q;
        ch_req_d = ch_req_q;
        dack_d   = dack_q;
        terr_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    win_d   = pick_idx;
                    hrq_d   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.hack) begin
                    dma_d    = 1'b1;
                    ch_req_d = N_CH'(onehot_of(3'(win_q)));
                    dack_d   = N_CH'(onehot_of(3'(win_q)));
                    state_d  = OWN;
                end else if (!bus.dreq[win_q]) begin
                    hrq_d   = 1'b0;
                    state_d = RELEASE;
                end else if (cnt_q == CW'(HACK_TIMEOUT - 1)) begin
                    terr_d  = 1'b1;
                    hrq_d   = 1'b0;
                    ptr_d   = ptr_next;
                    state_d = RELEASE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            OWN: begin
                // Only a rising eop completes; dreq and hack changes are ignored here.
                if (!eop_q && bus.eop) begin
                    hrq_d    = 1'b0;
                    dma_d    = 1'b0;
                    ch_req_d = '0;
                    dack_d   = '0;
                    ptr_d    = ptr_next;
                    state_d  = RELEASE;
                end
            end
            RELEASE: begin
                if (!bus.hack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            win_q    <= '0;
            ptr_q    <= '0;
            cnt_q    <= '0;
            eop_q    <= 1'b1;
            hrq_q    <= 1'b0;
            dma_q    <= 1'b0;
            ch_req_q <= '0;
            dack_q   <= '0;
            busy_q   <= 1'b0;
            terr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            eop_q    <= bus.eop;
            hrq_q    <= hrq_d;
            dma_q    <= dma_d;
            ch_req_q <= ch_req_d;
            dack_q   <= dack_d;
            busy_q   <= busy_d;
            terr_q   <= terr_d;
        end
    end

    assign bus.hrq         = hrq_q;
    assign bus.dma_ctrl    = dma_q;
    assign bus.ch_req      = ch_req_q;
    assign bus.dack        = dack_q;
    assign bus.busy        = busy_q;
    assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_dma_req_arbiter.sv
// Bench for dma_req_arbiter: directed scenarios plus random traffic against a cycle model.
module tb_dma_req_arbiter;
    import dma_pkg::*;

    localparam int N  = 2;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dma_req_arbiter_if #(.N_CH(N)) bus ();

    dma_req_arbiter #(
        .N_CH         (N),
        .HACK_TIMEOUT (TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: phase 0 idle, 1 requesting, 2 owning, 3 releasing.
    int           m_phase, m_ptr, m_win, m_wait;
    logic         m_eop_prev;
    logic         m_hrq, m_dma, m_busy, m_terr;
    logic [N-1:0] m_grant;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_ptr = 0; m_win = 0; m_wait = 0; m_eop_prev = 1'b1;
        m_hrq = 0; m_dma = 0; m_busy = 0; m_terr = 0; m_grant = '0;
    endtask

    task automatic model_step();
        m_terr = 0;
        case (m_phase)
            0: if (bus.dreq != 0) begin
                m_win = pick(bus.dreq, m_ptr); m_hrq = 1; m_wait = 0; m_phase = 1;
            end
            1: begin
                m_wait++;
                if (bus.hack) begin
                    m_dma = 1; m_grant = N'(1 << m_win); m_phase = 2;
                end else if (!bus.dreq[m_win]) begin
                    m_hrq = 0; m_phase = 3;
                end else if (m_wait == TO) begin
                    m_terr = 1; m_hrq = 0; m_ptr = (m_win + 1) % N; m_phase = 3;
                end
            end
            2: if (!m_eop_prev && bus.eop) begin
                m_hrq = 0; m_dma = 0; m_grant = '0; m_ptr = (m_win + 1) % N; m_phase = 3;
            end
            default: if (!bus.hack) m_phase = 0;
        endcase
        m_eop_prev = bus.eop;
        m_busy = (m_phase != 0);
    endtask

    task automatic check_all();
        chk("hrq", 8'(bus.hrq), 8'(m_hrq));
        chk("dma_ctrl", 8'(bus.dma_ctrl), 8'(m_dma));
        chk("ch_req", 8'(bus.ch_req), 8'(m_grant));
        chk("dack", 8'(bus.dack), 8'(m_grant));
        chk("busy", 8'(bus.busy), 8'(m_busy));
        chk("timeout_err", 8'(bus.timeout_err), 8'(m_terr));
    endtask

    task automatic cyc(input logic [N-1:0] d, input logic h, input logic e);
        bus.dreq = d; bus.hack = h; bus.eop = e;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        bus.dreq = '0; bus.hack = 1'b0; bus.eop = 1'b1;
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all();
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
    endtask

    // Idle -> granted -> eop edge -> idle, with hack already high on request.
    task automatic xfer(input logic [N-1:0] d, output logic [N-1:0] g);
        cyc(d, 1, 1);
        cyc(d, 1, 1);
        g = bus.ch_req;
        cyc(d, 1, 0);
        cyc(d, 1, 1);
        cyc('0, 0, 1);
    endtask

    logic [N-1:0] g, prev_g;
    logic [N-1:0] fair_exp [3];
    logic         dack_seen;
    logic         hrq_at_to;
    int           n;
    logic [N-1:0] rd;
    logic         rh, re;

    initial begin
        rst_n = 1'b1;
        do_reset();

        // Single request, hack three cycles after hrq, eop edge ten cycles later.
        cyc(2'b01, 0, 1);
        chk("t1_hrq_rise", 8'(bus.hrq), 8'h1);
        cyc(2'b01, 0, 1);
        cyc(2'b01, 0, 1);
        cyc(2'b01, 1, 1);
        chk("t1_ch_req", 8'(bus.ch_req), 8'h1);
        chk("t1_dack", 8'(bus.dack), 8'h1);
        chk("t1_dma_ctrl", 8'(bus.dma_ctrl), 8'h1);
        repeat (9) cyc(2'b01, 1, 0);
        cyc(2'b01, 1, 1);
        chk("t1_drop_dma", 8'(bus.dma_ctrl), 8'h0);
        chk("t1_drop_hrq", 8'(bus.hrq), 8'h0);
        cyc('0, 0, 1);
        chk("t1_idle", 8'(bus.busy), 8'h0);
        xfer(2'b11, g);
        chk("t1_ptr_next", 8'(g), 8'h2);

        // Fairness with both channels requesting.
        do_reset();
        fair_exp[0] = 2'b01; fair_exp[1] = 2'b10; fair_exp[2] = 2'b01;
        prev_g = '0;
        for (int t = 0; t < 3; t++) begin
            xfer(2'b11, g);
            chk("fair_grant", 8'(g), 8'(fair_exp[t]));
            chk("fair_no_repeat", 8'(g == prev_g), 8'h0);
            prev_g = g;
        end

        // Timeout with hack stuck low.
        do_reset();
        cyc(2'b10, 0, 1);
        n = 0;
        hrq_at_to = 1'b1;
        for (int i = 0; i < 40; i++) begin
            cyc(2'b10, 0, 1);
            n++;
            if (bus.timeout_err) begin
                hrq_at_to = bus.hrq;
                break;
            end
        end
        chk("to_cycles", 8'(n), 8'(TO));
        chk("to_hrq", 8'(hrq_at_to), 8'h0);
        cyc('0, 0, 1);
        chk("to_pulse_end", 8'(bus.timeout_err), 8'h0);
        xfer(2'b11, g);
        chk("to_ptr", 8'(g), 8'h1);

        // Abort: requesting channel withdraws before hack.
        do_reset();
        cyc(2'b01, 0, 1);
        chk("ab_hrq", 8'(bus.hrq), 8'h1);
        dack_seen = |bus.dack;
        cyc('0, 0, 1);
        chk("ab_hrq_fall", 8'(bus.hrq), 8'h0);
        dack_seen |= |bus.dack;
        cyc('0, 1, 1);
        chk("ab_wait_hack", 8'(bus.busy), 8'h1);
        dack_seen |= |bus.dack;
        cyc('0, 0, 1);
        chk("ab_idle", 8'(bus.busy), 8'h0);
        chk("ab_no_dack", 8'(dack_seen), 8'h0);
        cyc(2'b11, 1, 1);
        cyc(2'b11, 1, 1);
        chk("ab_ptr", 8'(bus.ch_req), 8'h1);

        // Asynchronous reset in the middle of ownership.
        #3 rst_n = 1'b0;
        #1;
        chk("ar_hrq", 8'(bus.hrq), 8'h0);
        chk("ar_dma", 8'(bus.dma_ctrl), 8'h0);
        chk("ar_ch_req", 8'(bus.ch_req), 8'h0);
        chk("ar_dack", 8'(bus.dack), 8'h0);
        model_reset();
        bus.dreq = '0; bus.hack = 1'b0; bus.eop = 1'b1;
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        xfer(2'b10, g);
        chk("ar_regrant", 8'(g), 8'h2);

        // Random traffic against the model.
        do_reset();
        rd = '0; rh = 1'b0; re = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) rd = N'($urandom);
            if ($urandom_range(0, 4) == 0) rh = ~rh;
            if ($urandom_range(0, 3) == 0) re = ~re;
            cyc(rd, rh, re);
            chk("rnd_dma_implies_hrq", 8'(bus.dma_ctrl && !bus.hrq), 8'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
